// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction words and field layouts, opcodes, and the
// stall/flush sequencer state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_t;

  typedef struct packed {
    opcode_t     opcode;
    regbits_t    rs;
    regbits_t    rt;
    logic [15:0] imm;
  } i_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the pipeline datapath and pipeline_controller.
//   master : datapath side, drives instruction/event inputs, receives controls
//   slave  : controller side, receives events, drives enables/flushes/halt/counters
interface pipeline_controller_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_types_pkg::*;

  word_t            instr_ID;
  word_t            instr_EX;
  logic             memRead_EX;
  logic             dmemREN_MEM;
  logic             dmemWEN_MEM;
  logic             dhit;
  logic             ihit;
  logic             branch_taken_EX;
  logic             jump_ID;
  logic             pc_en;
  logic             en_IFID;
  logic             en_IDEX;
  logic             en_EXMEM;
  logic             en_MEMWB;
  logic             flush_IFID;
  logic             flush_IDEX;
  logic             halt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instr_ID, instr_EX, memRead_EX, dmemREN_MEM, dmemWEN_MEM, dhit, ihit,
           branch_taken_EX, jump_ID,
    input  pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, flush_IFID, flush_IDEX, halt,
           cyc_cnt, stall_cnt
  );

  modport slave (
    input  instr_ID, instr_EX, memRead_EX, dmemREN_MEM, dmemWEN_MEM, dhit, ihit,
           branch_taken_EX, jump_ID,
    output pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, flush_IFID, flush_IDEX, halt,
           cyc_cnt, stall_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard comparator (combinational).
//   instr_ID   : instruction in IF/ID
//   instr_EX   : instruction in ID/EX
//   memRead_EX : EX instruction is a load
//   lu         : ID instruction reads the register the EX load is writing
module load_use_detect
  import cpu_types_pkg::*;
(
  input  word_t instr_ID,
  input  word_t instr_EX,
  input  logic  memRead_EX,
  output logic  lu
);

  r_t   id_r;
  r_t   ex_r;
  logic rt_is_source;
  logic unused_fields;

  assign id_r = r_t'(instr_ID);
  assign ex_r = r_t'(instr_EX);

  // rt is a source operand only for these formats; for loads/jumps it is a destination
  assign rt_is_source = (id_r.opcode == RTYPE) || (id_r.opcode == SW) ||
                        (id_r.opcode == BEQ)   || (id_r.opcode == BNE);

  assign lu = memRead_EX && (ex_r.rt != '0) &&
              ((ex_r.rt == id_r.rs) || ((ex_r.rt == id_r.rt) && rt_is_source));

  assign unused_fields = ^{id_r.rd, id_r.shamt, id_r.funct,
                           ex_r.opcode, ex_r.rs, ex_r.rd, ex_r.shamt, ex_r.funct};

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves memory waits,
// load-use hazards, taken branches (EX) and jumps (ID), sequences the HALT
// drain, and keeps saturating cycle/stall counters.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : pipeline_controller_if.slave (events in, enables/flushes/halt/counters out)
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input logic                  CLK,
  input logic                  nRST,
  pipeline_controller_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t      state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic dwait, lu, halt_id;
  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex;

  load_use_detect u_load_use_detect (
    .instr_ID   (bus.instr_ID),
    .instr_EX   (bus.instr_EX),
    .memRead_EX (bus.memRead_EX),
    .lu         (lu)
  );

  assign dwait   = (bus.dmemREN_MEM | bus.dmemWEN_MEM) & ~bus.dhit;
  assign halt_id = (bus.instr_ID[31:26] == HALT);

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    halt_d     = halt_q;
    pc_en      = 1'b0;
    en_ifid    = 1'b0;
    en_idex    = 1'b0;
    en_exmem   = 1'b0;
    en_memwb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dwait) begin
          // whole pipe frozen
        end else if (bus.branch_taken_EX) begin
          // younger lu/jump/halt belong to squashed instructions
          {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (lu) begin
          {en_idex, en_exmem, en_memwb} = '1;
          flush_idex = 1'b1;
        end else if (halt_id) begin
          {en_ifid, en_idex, en_exmem, en_memwb} = '1;
          flush_ifid = 1'b1;
          state_d    = DRAIN;
          drain_d    = DRAIN_INIT;
        end else if (bus.jump_ID && bus.ihit) begin
          {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
          flush_ifid = 1'b1;
        end else if (!bus.ihit) begin
          {en_ifid, en_idex, en_exmem, en_memwb} = '1;
          flush_ifid = 1'b1;
        end else begin
          {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
        end
      end
      DRAIN: begin
        flush_ifid = 1'b1;
        if (!dwait) begin
          {en_ifid, en_idex, en_exmem, en_memwb} = '1;
          if (drain_q == '0) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      HALTED: begin
        halt_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Controls must be quiet while reset is held, not just after the next edge
    if (!nRST) begin
      {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex} = '0;
    end
  end

  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (state_q != HALTED) begin
      if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
      if (!pc_en && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      drain_q <= '0;
      halt_q  <= 1'b0;
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halt_q  <= halt_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.en_IFID    = en_ifid;
  assign bus.en_IDEX    = en_idex;
  assign bus.en_EXMEM   = en_exmem;
  assign bus.en_MEMWB   = en_memwb;
  assign bus.flush_IFID = flush_ifid;
  assign bus.flush_IDEX = flush_idex;
  assign bus.halt       = halt_q;
  assign bus.cyc_cnt    = cyc_q;
  assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;
  import cpu_types_pkg::*;

  // control vector order: {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, flush_IFID, flush_IDEX}
  localparam logic [6:0] V_ALL    = 7'b11111_00;
  localparam logic [6:0] V_LU     = 7'b00111_01;
  localparam logic [6:0] V_BR     = 7'b11111_11;
  localparam logic [6:0] V_FRZ    = 7'b00000_00;
  localparam logic [6:0] V_HALTID = 7'b01111_10;
  localparam logic [6:0] V_JUMP   = 7'b11111_10;
  localparam logic [6:0] V_MISS   = 7'b01111_10;
  localparam logic [6:0] V_DADV   = 7'b01111_10;
  localparam logic [6:0] V_DFRZ   = 7'b00000_10;

  localparam word_t LW_2_1   = {6'h23, 5'd1, 5'd2, 16'd0};            // lw  $2,0($1)
  localparam word_t LW_0_1   = {6'h23, 5'd1, 5'd0, 16'd0};            // lw  $0,0($1)
  localparam word_t ADD_324  = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20}; // add $3,$2,$4
  localparam word_t ADD_304  = {6'h00, 5'd0, 5'd4, 5'd3, 5'd0, 6'h20}; // add $3,$0,$4
  localparam word_t SW_2_7   = {6'h2b, 5'd7, 5'd2, 16'd0};            // sw  $2,0($7)
  localparam word_t LW_2_7   = {6'h23, 5'd7, 5'd2, 16'd0};            // lw  $2,0($7)
  localparam word_t HALT_I   = {6'h3f, 26'd0};

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_fail;
  int   exp_cyc;
  int   exp_stall;

  pipeline_controller_if #(.CNT_W(32)) bus_if ();

  pipeline_controller #(
    .DRAIN_CYCLES (3),
    .CNT_W        (32)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] outs();
    return {bus_if.pc_en, bus_if.en_IFID, bus_if.en_IDEX, bus_if.en_EXMEM, bus_if.en_MEMWB,
            bus_if.flush_IFID, bus_if.flush_IDEX};
  endfunction

  task automatic set_idle();
    bus_if.instr_ID        = '0;
    bus_if.instr_EX        = '0;
    bus_if.memRead_EX      = 1'b0;
    bus_if.dmemREN_MEM     = 1'b0;
    bus_if.dmemWEN_MEM     = 1'b0;
    bus_if.dhit            = 1'b0;
    bus_if.ihit            = 1'b1;
    bus_if.branch_taken_EX = 1'b0;
    bus_if.jump_ID         = 1'b0;
  endtask

  // Advance one clock; update the counter model for the cycle just finished.
  task automatic tick(input logic stalled, input logic counting);
    @(posedge CLK);
    if (counting) begin
      exp_cyc++;
      if (stalled) exp_stall++;
    end
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    nRST = 1'b0;
    exp_cyc = 0;
    exp_stall = 0;
    #8;
    n_checks++;
    if (outs() !== V_FRZ) begin
      n_fail++; $display("FAIL reset_ctrl got %b want %b", outs(), V_FRZ);
    end
    n_checks++;
    if (bus_if.halt !== 1'b0) begin
      n_fail++; $display("FAIL reset_halt got %b want 0", bus_if.halt);
    end
    n_checks++;
    if (bus_if.cyc_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cyc got %0d want 0", bus_if.cyc_cnt);
    end
    n_checks++;
    if (bus_if.stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_stall got %0d want 0", bus_if.stall_cnt);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_run();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      #4;
      n_checks++;
      if (outs() !== V_ALL) begin
        n_fail++; $display("FAIL run_adv[%0d] got %b want %b", i, outs(), V_ALL);
      end
      n_checks++;
      if (bus_if.cyc_cnt !== 32'(exp_cyc)) begin
        n_fail++; $display("FAIL run_cyc[%0d] got %0d want %0d", i, bus_if.cyc_cnt, exp_cyc);
      end
      tick(1'b0, 1'b1);
    end
  endtask

  task automatic test_load_use();
    word_t ex_tab [4] = '{LW_2_1, LW_0_1, LW_2_1, LW_2_1};
    word_t id_tab [4] = '{ADD_324, ADD_304, SW_2_7, LW_2_7};
    logic [6:0] want [4] = '{V_LU, V_ALL, V_LU, V_ALL};
    for (int i = 0; i < 4; i++) begin
      set_idle();
      bus_if.instr_EX   = ex_tab[i];
      bus_if.instr_ID   = id_tab[i];
      bus_if.memRead_EX = 1'b1;
      #4;
      n_checks++;
      if (outs() !== want[i]) begin
        n_fail++; $display("FAIL load_use[%0d] got %b want %b", i, outs(), want[i]);
      end
      tick(~want[i][6], 1'b1);
      if (i == 0) begin
        // load has left EX; bubble now in EX, same consumer still in ID
        set_idle();
        bus_if.instr_ID = ADD_324;
        #4;
        n_checks++;
        if (outs() !== V_ALL) begin
          n_fail++; $display("FAIL load_use_after got %b want %b", outs(), V_ALL);
        end
        tick(1'b0, 1'b1);
      end
    end
    set_idle();
    #4;
    n_checks++;
    if (bus_if.stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL load_use_stall_cnt got %0d want %0d", bus_if.stall_cnt, exp_stall);
    end
    tick(1'b0, 1'b1);
  endtask

  task automatic test_dmem_wait();
    int stall_before;
    stall_before = exp_stall;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      bus_if.dmemREN_MEM     = 1'b1;
      bus_if.branch_taken_EX = (i > 0);
      #4;
      n_checks++;
      if (outs() !== V_FRZ) begin
        n_fail++; $display("FAIL dwait_freeze[%0d] got %b want %b", i, outs(), V_FRZ);
      end
      tick(1'b1, 1'b1);
    end
    set_idle();
    bus_if.dmemREN_MEM     = 1'b1;
    bus_if.dhit            = 1'b1;
    bus_if.branch_taken_EX = 1'b1;
    #4;
    n_checks++;
    if (outs() !== V_BR) begin
      n_fail++; $display("FAIL dwait_release_branch got %b want %b", outs(), V_BR);
    end
    n_checks++;
    if (bus_if.stall_cnt !== 32'(stall_before + 3)) begin
      n_fail++; $display("FAIL dwait_stall_cnt got %0d want %0d", bus_if.stall_cnt,
                         stall_before + 3);
    end
    tick(1'b0, 1'b1);
    set_idle();
    bus_if.dmemWEN_MEM = 1'b1;
    #4;
    n_checks++;
    if (outs() !== V_FRZ) begin
      n_fail++; $display("FAIL dwait_write got %b want %b", outs(), V_FRZ);
    end
    tick(1'b1, 1'b1);
  endtask

  task automatic test_branch_miss();
    set_idle();
    bus_if.branch_taken_EX = 1'b1;
    bus_if.ihit            = 1'b0;
    bus_if.instr_EX        = LW_2_1;
    bus_if.instr_ID        = ADD_324;
    bus_if.memRead_EX      = 1'b1;
    bus_if.jump_ID         = 1'b1;
    #4;
    n_checks++;
    if (outs() !== V_BR) begin
      n_fail++; $display("FAIL branch_miss_lu got %b want %b", outs(), V_BR);
    end
    tick(1'b0, 1'b1);
  endtask

  task automatic test_jump();
    logic       ih   [3] = '{1'b1, 1'b0, 1'b0};
    logic       jp   [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0] want [3] = '{V_JUMP, V_MISS, V_MISS};
    for (int i = 0; i < 3; i++) begin
      set_idle();
      bus_if.ihit    = ih[i];
      bus_if.jump_ID = jp[i];
      #4;
      n_checks++;
      if (outs() !== want[i]) begin
        n_fail++; $display("FAIL jump[%0d] got %b want %b", i, outs(), want[i]);
      end
      tick(~want[i][6], 1'b1);
    end
  endtask

  task automatic test_halt_drain();
    // ID: HALT; then drain: adv, frz, frz, adv, adv (last advancing), then HALTED
    logic       dw   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [6:0] want [5] = '{V_DADV, V_DFRZ, V_DFRZ, V_DADV, V_DADV};
    int cyc_frozen;
    set_idle();
    bus_if.instr_ID = HALT_I;
    #4;
    n_checks++;
    if (outs() !== V_HALTID) begin
      n_fail++; $display("FAIL halt_id got %b want %b", outs(), V_HALTID);
    end
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_idle();
      bus_if.dmemREN_MEM     = dw[i];
      bus_if.branch_taken_EX = (i == 0);
      bus_if.jump_ID         = (i == 3);
      #4;
      n_checks++;
      if (outs() !== want[i]) begin
        n_fail++; $display("FAIL drain[%0d] got %b want %b", i, outs(), want[i]);
      end
      n_checks++;
      if (bus_if.halt !== 1'b0) begin
        n_fail++; $display("FAIL drain_halt[%0d] got %b want 0", i, bus_if.halt);
      end
      tick(1'b1, 1'b1);
    end
    cyc_frozen = exp_cyc;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      bus_if.ihit = 1'b0;
      #4;
      n_checks++;
      if (bus_if.halt !== 1'b1) begin
        n_fail++; $display("FAIL halted_flag[%0d] got %b want 1", i, bus_if.halt);
      end
      n_checks++;
      if (outs() !== V_FRZ) begin
        n_fail++; $display("FAIL halted_ctrl[%0d] got %b want %b", i, outs(), V_FRZ);
      end
      n_checks++;
      if (bus_if.cyc_cnt !== 32'(cyc_frozen)) begin
        n_fail++; $display("FAIL halted_cyc[%0d] got %0d want %0d", i, bus_if.cyc_cnt,
                           cyc_frozen);
      end
      n_checks++;
      if (bus_if.stall_cnt !== 32'(exp_stall)) begin
        n_fail++; $display("FAIL halted_stall[%0d] got %0d want %0d", i, bus_if.stall_cnt,
                           exp_stall);
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_in_drain();
    // leave HALTED by reset
    set_idle();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    exp_cyc = 0;
    exp_stall = 0;
    #2;
    n_checks++;
    if (outs() !== V_ALL || bus_if.halt !== 1'b0) begin
      n_fail++; $display("FAIL rerun got %b/%b want %b/0", outs(), bus_if.halt, V_ALL);
    end
    tick(1'b0, 1'b1);
    bus_if.instr_ID = HALT_I;
    #4;
    n_checks++;
    if (outs() !== V_HALTID) begin
      n_fail++; $display("FAIL rid_halt_id got %b want %b", outs(), V_HALTID);
    end
    tick(1'b1, 1'b1);
    set_idle();
    #4;
    n_checks++;
    if (outs() !== V_DADV) begin
      n_fail++; $display("FAIL rid_drain got %b want %b", outs(), V_DADV);
    end
    #1;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (outs() !== V_FRZ) begin
      n_fail++; $display("FAIL rid_async_ctrl got %b want %b", outs(), V_FRZ);
    end
    n_checks++;
    if (bus_if.cyc_cnt !== 32'd0 || bus_if.stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rid_async_cnt got %0d/%0d want 0/0", bus_if.cyc_cnt,
                         bus_if.stall_cnt);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_cyc = 0;
    exp_stall = 0;
    for (int i = 0; i < 2; i++) begin
      set_idle();
      #4;
      n_checks++;
      if (outs() !== V_ALL || bus_if.halt !== 1'b0) begin
        n_fail++; $display("FAIL rid_run[%0d] got %b/%b want %b/0", i, outs(), bus_if.halt,
                           V_ALL);
      end
      n_checks++;
      if (bus_if.cyc_cnt !== 32'(exp_cyc) || bus_if.stall_cnt !== 32'(exp_stall)) begin
        n_fail++; $display("FAIL rid_cnt[%0d] got %0d/%0d want %0d/%0d", i, bus_if.cyc_cnt,
                           bus_if.stall_cnt, exp_cyc, exp_stall);
      end
      tick(1'b0, 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_run();
    test_load_use();
    test_dmem_wait();
    test_branch_miss();
    test_jump();
    test_halt_drain();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
